// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between one master (or interconnect) and the
// ahb_slave_mem slave. hready is the bus-level ready fed back by the interconnect.
interface ahb_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    hsel;
  logic [ADDR_WIDTH-1:0]   haddr;
  logic                    hwrite;
  logic [1:0]              htrans;
  logic [2:0]              hsize;
  logic [2:0]              hburst;
  logic                    hready;
  logic [DATA_WIDTH-1:0]   hwdata;
  logic [DATA_WIDTH/8-1:0] hstrb;
  logic [DATA_WIDTH-1:0]   hrdata;
  logic                    hreadyout;
  logic                    hresp;

  modport master (
    output hsel, haddr, hwrite, htrans, hsize, hburst, hready, hwdata, hstrb,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, hwrite, htrans, hsize, hburst, hready, hwdata, hstrb,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word-addressed memory slave with programmable wait states and
// byte-strobed writes. Optional out-of-range ERROR response is enabled by
// defining AHB_SLAVE_ERR_RESP_EN; otherwise the word index wraps modulo MEM_DEPTH.
module ahb_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic            hclk,
  input logic            hrst_n,
  ahb_slave_mem_if.slave bus
);

  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned WORD_W = ADDR_WIDTH - 2;
  localparam int unsigned NB     = DATA_WIDTH / 8;
  localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(MEM_DEPTH);
  localparam logic [3:0]        WS      = 4'(WAIT_STATES);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StData = 2'd1;
  localparam logic [1:0] StErr1 = 2'd2;
  localparam logic [1:0] StErr2 = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic              accept;
  logic              in_range;
  logic              ready_int;
  logic              complete;
  logic [WORD_W-1:0] word_mod;
  logic [IDX_W-1:0]  idx;
  logic              unused_bits;

  assign accept = bus.hsel & bus.htrans[1] & bus.hready;

`ifdef AHB_SLAVE_ERR_RESP_EN
  assign in_range = (bus.haddr[ADDR_WIDTH-1:2] < DEPTH_W);
`else
  assign in_range = 1'b1;
`endif

  // In range this is the identity; without the error option it gives the wrap-around.
  assign word_mod = word_q % DEPTH_W;
  assign idx      = word_mod[IDX_W-1:0];
  assign complete = (state_q == StData) && ready_int;

  assign unused_bits = ^{bus.hsize, bus.hburst, bus.haddr[1:0], word_mod};

  // Slave ready per state; a data phase ends once the wait counter reaches WAIT_STATES.
  always_comb begin
    ready_int = 1'b1;
    case (state_q)
      StData:  ready_int = (cnt_q == WS);
      StErr1:  ready_int = 1'b0;
      default: ;
    endcase
  end

  // Next-state: count wait states, and sample a new address phase whenever ready is high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    write_d = write_q;
    case (state_q)
      StData:  if (cnt_q != WS) cnt_d = cnt_q + 4'd1;
      StErr1:  state_d = StErr2;
      default: ;
    endcase
    if (ready_int) begin
      if (accept) begin
        word_d  = bus.haddr[ADDR_WIDTH-1:2];
        write_d = bus.hwrite;
        cnt_d   = 4'd0;
        state_d = in_range ? StData : StErr1;
      end else begin
        state_d = StIdle;
      end
    end
  end

  // Control state with asynchronous reset; an in-flight transfer is simply dropped.
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      word_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      write_q <= write_d;
    end
  end

  // Storage is never reset; write enabled byte lanes on the edge ending the data phase.
  always_ff @(posedge hclk) begin
    if (complete && write_q) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.hstrb[b]) mem[idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
      end
    end
  end

  assign bus.hreadyout = ready_int;
  assign bus.hrdata    = (complete && !write_q) ? mem[idx] : '0;
`ifdef AHB_SLAVE_ERR_RESP_EN
  assign bus.hresp     = (state_q == StErr1) || (state_q == StErr2);
`else
  assign bus.hresp     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: three instances (WAIT_STATES 0, 3, 2)
// share one stimulus driver; dut_sel picks which one is selected and observed.
module tb_ahb_slave_mem;

  logic clk;
  logic rst_n;

  logic        hsel_r;
  logic [31:0] haddr_r;
  logic        hwrite_r;
  logic [1:0]  htrans_r;
  logic [2:0]  hburst_r;
  logic [31:0] hwdata_r;
  logic [3:0]  hstrb_r;
  int          dut_sel;

  logic        rdy_o;
  logic        resp_o;
  logic [31:0] rd_o;

  int total;
  int bad;

  ahb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  ahb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  ahb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

  assign bus0.hsel = hsel_r && (dut_sel == 0);
  assign bus1.hsel = hsel_r && (dut_sel == 1);
  assign bus2.hsel = hsel_r && (dut_sel == 2);
  assign {bus0.haddr, bus0.hwrite, bus0.htrans, bus0.hburst} = {haddr_r, hwrite_r, htrans_r, hburst_r};
  assign {bus1.haddr, bus1.hwrite, bus1.htrans, bus1.hburst} = {haddr_r, hwrite_r, htrans_r, hburst_r};
  assign {bus2.haddr, bus2.hwrite, bus2.htrans, bus2.hburst} = {haddr_r, hwrite_r, htrans_r, hburst_r};
  assign {bus0.hwdata, bus0.hstrb, bus0.hsize} = {hwdata_r, hstrb_r, 3'b010};
  assign {bus1.hwdata, bus1.hstrb, bus1.hsize} = {hwdata_r, hstrb_r, 3'b010};
  assign {bus2.hwdata, bus2.hstrb, bus2.hsize} = {hwdata_r, hstrb_r, 3'b010};
  assign bus0.hready = bus0.hreadyout;
  assign bus1.hready = bus1.hreadyout;
  assign bus2.hready = bus2.hreadyout;

  ahb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .hclk(clk), .hrst_n(rst_n), .bus(bus0.slave)
  );
  ahb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut1 (
    .hclk(clk), .hrst_n(rst_n), .bus(bus1.slave)
  );
  ahb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut2 (
    .hclk(clk), .hrst_n(rst_n), .bus(bus2.slave)
  );

  always_comb begin
    rdy_o  = bus0.hreadyout;
    resp_o = bus0.hresp;
    rd_o   = bus0.hrdata;
    if (dut_sel == 1) begin
      rdy_o  = bus1.hreadyout;
      resp_o = bus1.hresp;
      rd_o   = bus1.hrdata;
    end else if (dut_sel == 2) begin
      rdy_o  = bus2.hreadyout;
      resp_o = bus2.hresp;
      rd_o   = bus2.hrdata;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat table for run_pipe.
  logic [31:0] p_addr [4];
  logic        p_wr   [4];
  logic [31:0] p_wd   [4];
  logic [3:0]  p_strb [4];
  logic [31:0] p_rd   [4];
  logic        p_resp [4];
  logic        p_resp0[4];
  int          p_low  [4];
  int          p_cycles;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic set_beat(input int k, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] strb);
    p_addr[k] = addr;
    p_wr[k]   = wr;
    p_wd[k]   = wd;
    p_strb[k] = strb;
  endtask

  task automatic drive_addr(input int k, input logic seq, input logic burst);
    hsel_r   = 1'b1;
    htrans_r = seq ? 2'b11 : 2'b10;
    hburst_r = burst ? 3'b011 : 3'b000;
    haddr_r  = p_addr[k];
    hwrite_r = p_wr[k];
  endtask

  // Pipelined transfers: next address is presented during the current data phase.
  task automatic run_pipe(input int n, input logic burst);
    int guard;
    p_cycles = 0;
    @(negedge clk);
    drive_addr(0, 1'b0, burst);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hwdata_r = p_wd[i];
      hstrb_r  = p_strb[i];
      if (i + 1 < n) begin
        drive_addr(i + 1, burst, burst);
      end else begin
        hsel_r   = 1'b0;
        htrans_r = 2'b00;
      end
      p_low[i]   = 0;
      p_resp0[i] = resp_o;
      guard      = 0;
      while (rdy_o !== 1'b1 && guard < 40) begin
        p_low[i]++;
        p_cycles++;
        guard++;
        @(negedge clk);
      end
      if (rdy_o !== 1'b1) chk("wait_bound", 32'(rdy_o), 32'd1);
      p_cycles++;
      p_rd[i]   = rd_o;
      p_resp[i] = resp_o;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total    = 0;
    bad      = 0;
    dut_sel  = 0;
    hsel_r   = 1'b0;
    haddr_r  = '0;
    hwrite_r = 1'b0;
    htrans_r = 2'b00;
    hburst_r = 3'b000;
    hwdata_r = '0;
    hstrb_r  = '0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hreadyout", 32'(rdy_o), 32'd1);
    chk("rst_hresp", 32'(resp_o), 32'd0);
    chk("rst_hrdata", rd_o, 32'd0);
    rst_n = 1'b1;

    // Simple write then read, zero wait states.
    set_beat(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    run_pipe(1, 1'b0);
    chk("ws0_wr_low", 32'(p_low[0]), 32'd0);
    set_beat(0, 1'b0, 32'h10, 32'h0, 4'h0);
    run_pipe(1, 1'b0);
    chk("ws0_rd_low", 32'(p_low[0]), 32'd0);
    chk("ws0_rd_data", p_rd[0], 32'hDEADBEEF);
    chk("ws0_rd_resp", 32'(p_resp[0]), 32'd0);

    // Partial strobes, then an all-zero strobe that must change nothing.
    set_beat(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    set_beat(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
    set_beat(2, 1'b0, 32'h20, 32'h0, 4'h0);
    run_pipe(3, 1'b0);
    chk("strb5_data", p_rd[2], 32'h11BB33DD);
    set_beat(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
    set_beat(1, 1'b0, 32'h22, 32'h0, 4'h0);
    run_pipe(2, 1'b0);
    chk("strb0_nochange", p_rd[1], 32'h11BB33DD);

    // Back-to-back write then read of the same word, low address bits ignored.
    set_beat(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
    set_beat(1, 1'b0, 32'h33, 32'h0, 4'h0);
    run_pipe(2, 1'b0);
    chk("b2b_cycles", 32'(p_cycles), 32'd2);
    chk("b2b_data", p_rd[1], 32'hCAFEF00D);

    // BUSY and unselected NONSEQ are not accepted.
    @(negedge clk);
    hsel_r = 1'b1; htrans_r = 2'b01; haddr_r = 32'h30; hwrite_r = 1'b1;
    @(negedge clk);
    chk("busy_ready", 32'(rdy_o), 32'd1);
    chk("busy_rdata", rd_o, 32'd0);
    hsel_r = 1'b0; htrans_r = 2'b10; hwdata_r = 32'h0; hstrb_r = 4'hF;
    @(negedge clk);
    chk("unsel_ready", 32'(rdy_o), 32'd1);
    chk("unsel_resp", 32'(resp_o), 32'd0);
    htrans_r = 2'b00;
    set_beat(0, 1'b0, 32'h30, 32'h0, 4'h0);
    run_pipe(1, 1'b0);
    chk("busy_nowrite", p_rd[0], 32'hCAFEF00D);

    // Out-of-range address.
    set_beat(0, 1'b1, 32'h0, 32'h01020304, 4'hF);
    run_pipe(1, 1'b0);
`ifdef AHB_SLAVE_ERR_RESP_EN
    set_beat(0, 1'b0, 32'h400, 32'h0, 4'h0);
    set_beat(1, 1'b0, 32'h0, 32'h0, 4'h0);
    run_pipe(2, 1'b0);
    chk("err1_low", 32'(p_low[0]), 32'd1);
    chk("err1_resp", 32'(p_resp0[0]), 32'd1);
    chk("err2_resp", 32'(p_resp[0]), 32'd1);
    chk("err2_rdata", p_rd[0], 32'd0);
    chk("after_err_resp", 32'(p_resp[1]), 32'd0);
    chk("after_err_data", p_rd[1], 32'h01020304);
`else
    set_beat(0, 1'b1, 32'h400, 32'h0BADF00D, 4'hF);
    set_beat(1, 1'b0, 32'h0, 32'h0, 4'h0);
    run_pipe(2, 1'b0);
    chk("wrap_resp", 32'(p_resp[1]), 32'd0);
    chk("wrap_data", p_rd[1], 32'h0BADF00D);
`endif

    // Three wait states: single read and 4-beat INCR bursts.
    dut_sel = 1;
    for (int k = 0; k < 4; k++) set_beat(k, 1'b1, 32'h40 + 32'(4 * k), 32'hA0B0C000 + 32'(k), 4'hF);
    run_pipe(4, 1'b1);
    chk("ws3_wrburst_cycles", 32'(p_cycles), 32'd16);
    for (int k = 0; k < 4; k++) set_beat(k, 1'b0, 32'h40 + 32'(4 * k), 32'h0, 4'h0);
    run_pipe(4, 1'b1);
    chk("ws3_rdburst_cycles", 32'(p_cycles), 32'd16);
    for (int k = 0; k < 4; k++) begin
      chk("ws3_burst_low", 32'(p_low[k]), 32'd3);
      chk("ws3_burst_data", p_rd[k], 32'hA0B0C000 + 32'(k));
    end
    set_beat(0, 1'b0, 32'h48, 32'h0, 4'h0);
    run_pipe(1, 1'b0);
    chk("ws3_single_low", 32'(p_low[0]), 32'd3);
    chk("ws3_single_data", p_rd[0], 32'hA0B0C002);

    // Reset asserted during the wait state of a write.
    dut_sel = 2;
    set_beat(0, 1'b1, 32'h8, 32'h55AA55AA, 4'hF);
    run_pipe(1, 1'b0);
    chk("ws2_low", 32'(p_low[0]), 32'd2);
    @(negedge clk);
    hsel_r = 1'b1; htrans_r = 2'b10; haddr_r = 32'h8; hwrite_r = 1'b1;
    @(negedge clk);
    hsel_r = 1'b0; htrans_r = 2'b00; hwdata_r = 32'hFFFFFFFF; hstrb_r = 4'hF;
    chk("ws2_inwait", 32'(rdy_o), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(rdy_o), 32'd1);
    chk("async_rst_resp", 32'(resp_o), 32'd0);
    chk("async_rst_rdata", rd_o, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_beat(0, 1'b0, 32'h8, 32'h0, 4'h0);
    run_pipe(1, 1'b0);
    chk("rst_mem_kept", p_rd[0], 32'h55AA55AA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, haddr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, hwdata/hrdata width (legal values: 32 only).
REQ-003 SHALL have parameter MEM_DEPTH, default 256, number of DATA_WIDTH words of storage.
REQ-004 SHALL have parameter WAIT_STATES, default 0, range 0-15, hreadyout-low cycles inserted per OKAY data phase.
REQ-005 SHALL have port hclk  input  1  the only clock, rising edge.
REQ-006 SHALL have port hrst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port hsel  input  1  slave select.
REQ-008 SHALL have port haddr  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have port hwrite  input  1  1=write, 0=read.
REQ-010 SHALL have port htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-011 SHALL have ports hsize and hburst  input  3 each  accepted, not decoded.
REQ-012 SHALL have port hready  input  1  bus-level ready (previous transfer complete).
REQ-013 SHALL have port hwdata  input  DATA_WIDTH  write data, data phase.
REQ-014 SHALL have port hstrb  input  DATA_WIDTH/8  write byte strobes, data phase.
REQ-015 SHALL have port hrdata  output  DATA_WIDTH  read data.
REQ-016 SHALL have port hreadyout  output  1  slave ready.
REQ-017 SHALL have port hresp  output  1  0=OKAY, 1=ERROR.

Function
REQ-018 Transfer SHALL be accepted at a rising edge where hsel=1, htrans[1]=1, hready=1; haddr, hwrite captured into address-phase registers.
REQ-019 IDLE/BUSY or hsel=0 with hready=1 SHALL not be accepted; next cycle zero-wait OKAY (hreadyout=1, hresp=0).
REQ-020 FSM states: IDLE, DATA, ERR1, ERR2.
REQ-021 IDLE: hreadyout=1, hresp=0; accepted in-range transfer -> DATA with wait counter cleared; out-of-range (with REQ-031 macro) -> ERR1.
REQ-022 DATA: hreadyout=0 while wait counter < WAIT_STATES (counter increments each cycle), hreadyout=1 when counter == WAIT_STATES; hresp=0.
REQ-023 DATA completing cycle: new accepted transfer -> DATA/ERR1 per REQ-021 (back-to-back pipelining, no bubble); else -> IDLE.
REQ-024 ERR1: hreadyout=0, hresp=1 -> ERR2. ERR2: hreadyout=1, hresp=1; new transfer accepted per REQ-021 (incl. master-driven htrans=IDLE cancel).
REQ-025 Word index = captured haddr[ADDR_WIDTH-1:2]; haddr[1:0] ignored.
REQ-026 Write SHALL update memory at the edge ending the data phase (hreadyout=1), only byte lanes with hstrb[i]=1; hstrb=0 -> no change.
REQ-027 Read: hrdata = mem[captured index] while in DATA with hreadyout=1; hrdata=0 in all other cycles.
REQ-028 Write followed back-to-back by read of same address SHALL return the newly written data.
REQ-029 Memory contents SHALL not be reset; unwritten locations read X in simulation.

Reset
REQ-030 hrst_n=0 SHALL asynchronously force state=IDLE, wait counter=0, captured registers=0, hreadyout=1, hresp=0, hrdata=0; in-flight transfer dropped, no memory write; first post-reset edge behaves as IDLE.

Configuration
REQ-031 Macro AHB_SLAVE_ERR_RESP_EN: defined -> word index >= MEM_DEPTH yields two-cycle ERROR (ERR1/ERR2), no memory access, hrdata=0; undefined -> ERR1/ERR2 unreachable, hresp tied 0, index taken modulo MEM_DEPTH (wrap-around).

Verification
REQ-032 WAIT_STATES=0: NONSEQ write 0x10 data 0xDEADBEEF hstrb=0xF, then NONSEQ read 0x10 -> read data phase hreadyout=1, hrdata=0xDEADBEEF, hresp=0.
REQ-033 Write 0x20 = 0x11223344, then write 0x20 data 0xAABBCCDD hstrb=0x5, read 0x20 -> 0x11BB33DD.
REQ-034 WAIT_STATES=3: single read -> hreadyout low exactly 3 cycles, then high with data; 4-beat INCR back-to-back -> 16 cycles total data phases, no idle gaps.
REQ-035 Macro defined, MEM_DEPTH=256: read 0x400 -> hreadyout 0/hresp 1, then 1/1, hrdata=0; following read 0x0 OKAY. Macro undefined: write 0x400 lands at index 0.
REQ-036 Assert hrst_n=0 in wait state of write to 0x8 (WAIT_STATES=2) -> outputs reset immediately, location 0x8 unchanged.
